// File: rtl/valid_sync_pkg.sv
// Shared limits, channel mode encoding and filter counter sizing for valid_sync_array.
package valid_sync_pkg;

  localparam int MAX_CH     = 32;
  localparam int MAX_DEPTH  = 8;
  localparam int MAX_FILTER = 15;

  typedef enum logic {
    MODE_LEVEL  = 1'b0,
    MODE_TOGGLE = 1'b1
  } chan_mode_e;

  function automatic int filter_cnt_w(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_shift_reg.sv
// Single-bit DEPTH-stage synchroniser chain with synchronous reset to 0.
module sync_shift_reg
  import valid_sync_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  // Attribute lets placement keep the stages adjacent and timing tools spot the crossing.
  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb stage_d = {stage_q[DEPTH-2:0], din};

  always_ff @(posedge clock) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/valid_sync_array.sv
// CH-channel async valid/level/toggle sink: sync chains, event pulse, sticky pending/overrun.
// Optional glitch filter between chain and io_out when SYNC_FILTER_EN is defined.
module valid_sync_array
  import valid_sync_pkg::*;
#(
  parameter int            CH            = 4,
  parameter int            DEPTH         = 3,
  parameter logic [CH-1:0] TOGGLE_MASK   = '0,
  parameter int            FILTER_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CH-1:0] io_in,
  input  logic [CH-1:0] io_ack,
  output logic [CH-1:0] io_out,
  output logic [CH-1:0] io_event,
  output logic [CH-1:0] io_pending,
  output logic [CH-1:0] io_overrun
);

  if (CH < 1 || CH > MAX_CH) begin : g_bad_ch
    $error("valid_sync_array: CH out of range");
  end
  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("valid_sync_array: DEPTH out of range");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > MAX_FILTER) begin : g_bad_filter
    $error("valid_sync_array: FILTER_CYCLES out of range");
  end

  logic [CH-1:0] chain_out, ev;
  logic [CH-1:0] prev_q, prev_d;
  logic [CH-1:0] pending_q, pending_d;
  logic [CH-1:0] overrun_q, overrun_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam chan_mode_e MODE = TOGGLE_MASK[i] ? MODE_TOGGLE : MODE_LEVEL;

    sync_shift_reg #(.DEPTH(DEPTH)) u_sync (
      .clock (clock),
      .reset (reset),
      .din   (io_in[i]),
      .dout  (chain_out[i])
    );

    assign ev[i] = (MODE == MODE_TOGGLE) ? (io_out[i] ^ prev_q[i])
                                         : (io_out[i] & ~prev_q[i]);
  end

`ifdef SYNC_FILTER_EN
  localparam int            CW       = filter_cnt_w(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CH-1:0]         out_q, out_d;

  // io_out only follows chain_out once it has disagreed for FILTER_CYCLES edges in a row.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    for (int i = 0; i < CH; i++) begin
      if (chain_out[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        out_d[i] = chain_out[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign io_out = out_q;
`else
  assign io_out = chain_out;
`endif

  // A fresh event beats a same-cycle ack for pending; the ack still clears overrun.
  always_comb begin
    prev_d    = io_out;
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int i = 0; i < CH; i++) begin
      if (ev[i] && pending_q[i] && !io_ack[i]) begin
        overrun_d[i] = 1'b1;
      end else if (ev[i]) begin
        pending_d[i] = 1'b1;
        if (io_ack[i]) overrun_d[i] = 1'b0;
      end else if (io_ack[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign io_event   = ev;
  assign io_pending = pending_q;
  assign io_overrun = overrun_q;

endmodule

// File: tb/tb_valid_sync_array.sv
// Directed plus random bench for valid_sync_array against a queue-based behavioural model.
module tb_valid_sync_array;

  localparam int         CH    = 4;
  localparam int         DEPTH = 3;
  localparam int         FC    = 2;
  localparam logic [3:0] TMASK = 4'b1010;
`ifdef SYNC_FILTER_EN
  localparam int LAT = DEPTH + FC;
`else
  localparam int LAT = DEPTH;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] io_in, io_ack;
  logic [CH-1:0] io_out, io_event, io_pending, io_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_cnt [CH];

  always #5 clk = ~clk;

  valid_sync_array #(
    .CH(CH), .DEPTH(DEPTH), .TOGGLE_MASK(TMASK), .FILTER_CYCLES(FC)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .io_in      (io_in),
    .io_ack     (io_ack),
    .io_out     (io_out),
    .io_event   (io_event),
    .io_pending (io_pending),
    .io_overrun (io_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: io_in history queue, spec-level event/pending rules.
  logic [CH-1:0] hist [$];
  logic [CH-1:0] m_out = '0, m_prev = '0, m_pend = '0, m_ov = '0;
  int            diff_len [CH];

  function automatic logic [CH-1:0] m_event();
    logic [CH-1:0] e;
    for (int i = 0; i < CH; i++)
      e[i] = TMASK[i] ? (m_out[i] != m_prev[i]) : (m_out[i] && !m_prev[i]);
    return e;
  endfunction

  always @(posedge clk) begin
    logic [CH-1:0] ev, chain_pre, dropped;
    ev = m_event();
    if (reset) begin
      hist = {};
      for (int k = 0; k < DEPTH; k++) hist.push_back('0);
      m_out = '0; m_prev = '0; m_pend = '0; m_ov = '0;
      for (int i = 0; i < CH; i++) diff_len[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (ev[i]) begin
          if (m_pend[i] && !io_ack[i]) m_ov[i] = 1'b1;
          else if (io_ack[i])          m_ov[i] = 1'b0;
          m_pend[i] = 1'b1;
        end else if (io_ack[i]) begin
          m_pend[i] = 1'b0;
          m_ov[i]   = 1'b0;
        end
      end
      m_prev    = m_out;
      chain_pre = hist[0];
      hist.push_back(io_in);
      dropped   = hist.pop_front();
`ifdef SYNC_FILTER_EN
      for (int i = 0; i < CH; i++) begin
        if (chain_pre[i] == m_out[i]) diff_len[i] = 0;
        else diff_len[i]++;
        if (diff_len[i] >= FC) begin
          m_out[i]    = chain_pre[i];
          diff_len[i] = 0;
        end
      end
`else
      m_out = hist[0];
`endif
    end
  end

  always @(negedge clk) begin
    chk("out",     io_out,     m_out);
    chk("event",   io_event,   m_event());
    chk("pending", io_pending, m_pend);
    chk("overrun", io_overrun, m_ov);
    for (int i = 0; i < CH; i++) if (io_event[i]) ev_cnt[i]++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < CH; i++) begin ev_cnt[i] = 0; diff_len[i] = 0; end
    for (int k = 0; k < DEPTH; k++) hist.push_back('0);
    reset = 1'b1; io_in = '0; io_ack = '0;
    step(2);
    chk("rst_all", {io_out, io_event, io_pending, io_overrun}, 32'h0);
    reset = 1'b0;
    step(4);

    // Latency and single-cycle event on a level channel
    io_in[0] = 1'b1;
    step(LAT - 1);
    chk("lat_out_early", io_out[0], 1'b0);
    step(1);
    chk("lat_out", io_out[0], 1'b1);
    chk("lat_event", io_event[0], 1'b1);
    step(1);
    chk("lat_event_single", io_event[0], 1'b0);
    chk("lat_pending", io_pending[0], 1'b1);

    // Level falling edge is silent; toggle channel fires on both edges
    base = ev_cnt[0];
    io_in[0] = 1'b0;
    step(LAT + 3);
    chk("level_fall_no_event", ev_cnt[0] - base, 0);
    base = ev_cnt[1];
    io_in[1] = 1'b1;
    step(LAT + 1);
    chk("toggle_pending", io_pending[1], 1'b1);
    step(20 - LAT - 1);
    io_in[1] = 1'b0;
    step(LAT + 3);
    chk("toggle_two_events", ev_cnt[1] - base, 2);
    chk("toggle_overrun", io_overrun[1], 1'b1);

    // Ack clears pending; ack coincident with an event keeps pending and clears overrun
    io_in[2] = 1'b1;
    step(LAT + 1);
    chk("ack_pend_set", io_pending[2], 1'b1);
    io_ack[2] = 1'b1;
    step(1);
    io_ack[2] = 1'b0;
    chk("ack_clears", io_pending[2], 1'b0);
    io_in[2] = 1'b0; step(LAT + 2);
    io_in[2] = 1'b1; step(LAT + 1);
    io_in[2] = 1'b0; step(LAT + 2);
    io_in[2] = 1'b1; step(LAT);
    chk("ack_coinc_event", io_event[2], 1'b1);
    io_ack[2] = 1'b1;
    step(1);
    io_ack[2] = 1'b0;
    chk("ack_coinc_pend", io_pending[2], 1'b1);
    chk("ack_coinc_ovr", io_overrun[2], 1'b0);

    // Reset mid-flight with a toggle input held high through deassertion
    base = ev_cnt[3];
    io_in[3] = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    chk("midrst_all_0", {io_out, io_event, io_pending, io_overrun}, 32'h0);
    step(1);
    chk("midrst_all_1", {io_out, io_event, io_pending, io_overrun}, 32'h0);
    reset = 1'b0;
    step(LAT - 1);
    chk("midrst_out_early", io_out[3], 1'b0);
    step(1);
    chk("midrst_out", io_out[3], 1'b1);
    step(6);
    chk("midrst_one_event", ev_cnt[3] - base, 1);

`ifdef SYNC_FILTER_EN
    // Short pulse is filtered out; a long one passes with DEPTH+FC latency
    base = ev_cnt[0];
    io_in[0] = 1'b1; step(1);
    io_in[0] = 1'b0; step(10);
    chk("filt_glitch_events", ev_cnt[0] - base, 0);
    chk("filt_glitch_out", io_out[0], 1'b0);
    io_in[0] = 1'b1;
    step(4);
    chk("filt_out_early", io_out[0], 1'b0);
    io_in[0] = 1'b0;
    step(1);
    chk("filt_out", io_out[0], 1'b1);
    step(8);
    chk("filt_one_event", ev_cnt[0] - base, 1);
`endif

    // Random traffic, model checked every cycle by the negedge monitor
    for (int c = 0; c < 10000; c++) begin
      logic [CH-1:0] flip;
      for (int i = 0; i < CH; i++) flip[i] = ($urandom_range(7) == 0);
      io_in  = io_in ^ flip;
      io_ack = CH'($urandom_range(15)) & CH'($urandom_range(15));
      reset  = ($urandom_range(499) == 0);
      step(1);
    end
    reset = 1'b0; io_ack = '0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
